// File: rtl/qspi_row_tx.sv
// -----------------------------------------------------------------------------
// qspi_row_tx
// Pulls 16-bit words from the FIFO-to-SPI row interface and serialises each
// word onto a 4-lane QSPI bus (SPI mode 0, MSB nibble first). One row frame
// is WORDS_PER_ROW words (8 data words, then 1 address word) sent inside a
// single chip-select window. SCLK is derived from clk via a divider.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   tx_enable  permit new frames to start
//   row_valid  FIFO holds a complete row (sampled only while idle)
//   rdata_spi  current word from the row interface
//   shift_en   one-cycle pulse: word captured, upstream advances
//   qspi_sclk  serial clock, idle low
//   qspi_cs_n  chip select, active low
//   qspi_io    data lanes
//   qspi_oe    lane output enable
//   busy       frame in progress (cs_n low or inter-frame gap running)
//   row_done   one-cycle pulse when the last nibble of a frame completes
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module qspi_row_tx #(
  parameter int CLK_DIV       = 2,
  parameter int WORDS_PER_ROW = 9,
  parameter int CS_SETUP      = 2,
  parameter int CS_GAP        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_enable,
  input  logic        row_valid,
  input  logic [15:0] rdata_spi,
  output logic        shift_en,
  output logic        qspi_sclk,
  output logic        qspi_cs_n,
  output logic [3:0]  qspi_io,
  output logic        qspi_oe,
  output logic        busy,
  output logic        row_done
);

  localparam int WCW     = $clog2(WORDS_PER_ROW + 1);
  localparam int DCW     = $clog2(CLK_DIV + 1);
  localparam int TMR_MAX = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
  localparam int TCW     = $clog2(TMR_MAX + 1);

  localparam logic [WCW-1:0] LAST_WORD  = WCW'(WORDS_PER_ROW - 1);
  localparam logic [DCW-1:0] DIV_LAST   = DCW'(CLK_DIV - 1);
  localparam logic [TCW-1:0] SETUP_LAST = TCW'(CS_SETUP - 1);
  localparam logic [TCW-1:0] GAP_LAST   = TCW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]     nib_cnt_q, nib_cnt_d;
  logic [DCW-1:0] div_cnt_q, div_cnt_d;
  logic [TCW-1:0] tmr_q, tmr_d;
  logic [15:0]    sreg_q, sreg_d;
  logic           shift_en_q, shift_en_d;
  logic           sclk_q, sclk_d;
  logic           cs_n_q, cs_n_d;
  logic           oe_q, oe_d;
  logic           busy_q, busy_d;
  logic           row_done_q, row_done_d;

  // State register and all output/counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      nib_cnt_q  <= 2'd0;
      div_cnt_q  <= '0;
      tmr_q      <= '0;
      sreg_q     <= 16'h0000;
      shift_en_q <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      row_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      nib_cnt_q  <= nib_cnt_d;
      div_cnt_q  <= div_cnt_d;
      tmr_q      <= tmr_d;
      sreg_q     <= sreg_d;
      shift_en_q <= shift_en_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      row_done_q <= row_done_d;
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    nib_cnt_d  = nib_cnt_q;
    div_cnt_d  = div_cnt_q;
    tmr_d      = tmr_q;
    sreg_d     = sreg_q;
    shift_en_d = 1'b0;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    row_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_enable && row_valid) begin
          state_d    = S_SETUP;
          cs_n_d     = 1'b0;
          oe_d       = 1'b1;
          busy_d     = 1'b1;
          word_cnt_d = '0;
          tmr_d      = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SETUP: begin
        if (tmr_q == SETUP_LAST) begin
          // shift_en is registered, so it is high during the LOAD cycle
          state_d    = S_LOAD;
          shift_en_d = 1'b1;
          tmr_d      = '0;
        end else begin
          tmr_d = tmr_q + TCW'(1);
        end
      end

      S_LOAD: begin
        // Upstream sees shift_en on this same edge and only then advances,
        // so rdata_spi still holds the word belonging to this slot.
        sreg_d    = rdata_spi;
        nib_cnt_d = 2'd0;
        div_cnt_d = '0;
        sclk_d    = 1'b0;
        state_d   = S_SHIFT;
      end

      S_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (nib_cnt_q == 2'd3) begin
              if (word_cnt_q < LAST_WORD) begin
                word_cnt_d = word_cnt_q + WCW'(1);
                shift_en_d = 1'b1;
                state_d    = S_LOAD;
              end else begin
                // Clearing sreg also drives the lanes to zero (io is sreg top)
                row_done_d = 1'b1;
                cs_n_d     = 1'b1;
                oe_d       = 1'b0;
                sreg_d     = 16'h0000;
                tmr_d      = '0;
                state_d    = S_GAP;
              end
            end else begin
              nib_cnt_d = nib_cnt_q + 2'd1;
              sreg_d    = {sreg_q[11:0], 4'h0};
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DCW'(1);
        end
      end

      S_GAP: begin
        if (tmr_q == GAP_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TCW'(1);
        end
      end

      default: begin
        state_d    = S_IDLE;
        word_cnt_d = '0;
        nib_cnt_d  = 2'd0;
        div_cnt_d  = '0;
        tmr_d      = '0;
        sreg_d     = 16'h0000;
        sclk_d     = 1'b0;
        cs_n_d     = 1'b1;
        oe_d       = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  assign shift_en  = shift_en_q;
  assign qspi_sclk = sclk_q;
  assign qspi_cs_n = cs_n_q;
  // The top nibble of the shift register is the lane value.
  assign qspi_io   = sreg_q[15:12];
  assign qspi_oe   = oe_q;
  assign busy      = busy_q;
  assign row_done  = row_done_q;

endmodule

// File: tb/tb_qspi_row_tx.sv
// -----------------------------------------------------------------------------
// Bench for qspi_row_tx. Two instances run side by side from shared
// tx_enable/row_valid: instance 0 with CLK_DIV=2, instance 1 with CLK_DIV=1.
// Each has its own upstream row model. The expected waveform is derived from
// the cycle offset inside a frame using plain arithmetic.
// -----------------------------------------------------------------------------
module tb_qspi_row_tx;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tx_enable = 1'b0;
  logic              row_valid = 1'b0;
  logic [1:0][15:0]  rdata;
  logic [1:0]        se, sclk, csn, oe, busy, rd;
  logic [1:0][3:0]   io;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qspi_row_tx #(.CLK_DIV(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .row_valid(row_valid),
    .rdata_spi(rdata[0]), .shift_en(se[0]), .qspi_sclk(sclk[0]),
    .qspi_cs_n(csn[0]), .qspi_io(io[0]), .qspi_oe(oe[0]), .busy(busy[0]),
    .row_done(rd[0])
  );

  qspi_row_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .row_valid(row_valid),
    .rdata_spi(rdata[1]), .shift_en(se[1]), .qspi_sclk(sclk[1]),
    .qspi_cs_n(csn[1]), .qspi_io(io[1]), .qspi_oe(oe[1]), .busy(busy[1]),
    .row_done(rd[1])
  );

  // Row contents: frame 0 is the hand-written row, later rows are generated.
  function automatic logic [15:0] word(input int f, input int w);
    logic [15:0] t [9] = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718, 16'h293A,
                           16'h4B5C, 16'h6D7E, 16'h8F90, 16'h0707};
    if (f == 0) return t[w];
    return 16'(f * 32'h1357 + w * 32'h2B1D) ^ 16'h5AC3;
  endfunction

  function automatic int divof(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Cycles per word, cycles with cs_n low, whole frame length.
  function automatic int wlen(input int i);  return 1 + 8 * divof(i);  endfunction
  function automatic int txlen(input int i); return 2 + 9 * wlen(i);   endfunction
  function automatic int flen(input int i);  return txlen(i) + 4;      endfunction

  // Expected outputs at cycle offset kk of a frame (kk < 0 means idle).
  function automatic void model_out(input int i, input int kk, input int f,
      output logic ecs, output logic esc, output logic eoe, output logic ebz,
      output logic ese, output logic erd, output logic [3:0] eio);
    int d, j, w, r, s, nib;
    logic [15:0] wd;
    d = divof(i);
    ecs = 1'b1; esc = 1'b0; eoe = 1'b0; ebz = 1'b0; ese = 1'b0; erd = 1'b0;
    eio = 4'h0;
    if (kk >= 0 && kk < txlen(i)) begin
      ecs = 1'b0; eoe = 1'b1; ebz = 1'b1;
      if (kk >= 2) begin
        j = kk - 2; w = j / wlen(i); r = j % wlen(i);
        if (r == 0) begin
          ese = 1'b1;
          if (w > 0) begin
            wd = word(f, w - 1);
            eio = wd[3:0];
          end
        end else begin
          s = r - 1; nib = s / (2 * d);
          esc = ((s % (2 * d)) >= d);
          wd = word(f, w);
          eio = wd[(15 - 4 * nib) -: 4];
        end
      end
    end else if (kk >= txlen(i)) begin
      ebz = 1'b1;
      erd = (kk == txlen(i));
    end
  endfunction

  task automatic cmp(input string nm, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d at %0t: got %0h expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  // Model state: frame offset, frame index in use, upstream row pointer.
  int k   [2] = '{-1, -1};
  int fm  [2] = '{0, 0};
  int fu  [2] = '{0, 0};
  int ptr [2] = '{0, 0};

  always_comb begin
    for (int i = 0; i < 2; i++) rdata[i] = word(fu[i], ptr[i]);
  end

  // Upstream row interface and frame-offset tracker.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        k[i] <= -1;
        if (ptr[i] != 0) fu[i] <= fu[i] + 1;
        ptr[i] <= 0;
      end else begin
        if (k[i] < 0) begin
          if (tx_enable && row_valid) begin
            k[i]  <= 0;
            fm[i] <= fu[i];
          end
        end else if (k[i] == flen(i) - 1) begin
          k[i] <= -1;
        end else begin
          k[i] <= k[i] + 1;
        end
        if (se[i]) begin
          if (ptr[i] == 8) begin
            ptr[i] <= 0;
            fu[i]  <= fu[i] + 1;
          end else begin
            ptr[i] <= ptr[i] + 1;
          end
        end
      end
    end
  end

  // Per-frame statistics gathered from the DUT outputs.
  int se_cnt [2], rise_cnt [2], low_cnt [2], se_total [2], rd_cnt [2];
  int last_se [2], last_rise [2], last_low [2], last_gap [2];
  int since_rd [2] = '{1000, 1000};
  logic prev_cs [2] = '{1'b1, 1'b1};
  logic prev_sc [2] = '{1'b0, 1'b0};
  logic [3:0] nib_log [36];

  // Per-cycle comparison against the model plus statistics collection.
  always @(negedge clk) begin
    logic ecs, esc, eoe, ebz, ese, erd;
    logic [3:0] eio;
    for (int i = 0; i < 2; i++) begin
      model_out(i, k[i], fm[i], ecs, esc, eoe, ebz, ese, erd, eio);
      cmp("cs_n", i, int'(csn[i]), int'(ecs));
      cmp("sclk", i, int'(sclk[i]), int'(esc));
      cmp("oe", i, int'(oe[i]), int'(eoe));
      cmp("busy", i, int'(busy[i]), int'(ebz));
      cmp("shift_en", i, int'(se[i]), int'(ese));
      cmp("row_done", i, int'(rd[i]), int'(erd));
      cmp("io", i, int'(io[i]), int'(eio));

      if (rd[i]) begin
        rd_cnt[i]++;
        since_rd[i] = 0;
      end else begin
        since_rd[i]++;
      end
      if (se[i]) se_total[i]++;
      if (prev_cs[i] && !csn[i]) begin
        se_cnt[i] = 0; rise_cnt[i] = 0; low_cnt[i] = 0;
        last_gap[i] = since_rd[i];
      end
      if (!csn[i]) begin
        low_cnt[i]++;
        if (se[i]) se_cnt[i]++;
        if (!prev_sc[i] && sclk[i]) begin
          if (i == 0 && rise_cnt[i] < 36) nib_log[rise_cnt[i]] = io[i];
          rise_cnt[i]++;
        end
      end
      if (!prev_cs[i] && csn[i]) begin
        last_se[i] = se_cnt[i]; last_rise[i] = rise_cnt[i]; last_low[i] = low_cnt[i];
      end
      prev_cs[i] = csn[i];
      prev_sc[i] = sclk[i];
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_start();
    int n = 0;
    while (csn[0] !== 1'b0 && n < 50) begin step(1); n++; end
    cmp("start_timeout", 0, int'(n < 50), 1);
  endtask

  task automatic wait_rd(input int target);
    int n = 0;
    while (rd_cnt[0] < target && n < 1000) begin step(1); n++; end
    cmp("row_done_timeout", 0, int'(n < 1000), 1);
  endtask

  task automatic wait_se(input int target);
    int n = 0;
    while (se_cnt[0] < target && n < 200) begin step(1); n++; end
    cmp("shift_en_timeout", 0, int'(n < 200), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 2'b00 && n < 500) begin step(1); n++; end
    cmp("idle_timeout", 0, int'(n < 500), 1);
  endtask

  initial begin
    int rd0;
    // Reset values
    step(3);
    cmp("rst_cs_n", 0, int'(csn[0]), 1);
    cmp("rst_sclk", 0, int'(sclk[0]), 0);
    cmp("rst_oe", 0, int'(oe[0]), 0);
    cmp("rst_io", 0, int'(io[0]), 0);
    cmp("rst_busy", 0, int'(busy[0]), 0);
    cmp("rst_shift_en", 0, int'(se[0]), 0);
    rst_n = 1'b1;
    step(2);

    // Enabled but no row available
    tx_enable = 1'b1;
    step(50);
    cmp("idle_se_total", 0, se_total[0], 0);
    cmp("idle_se_total", 1, se_total[1], 0);
    cmp("idle_busy", 0, int'(busy[0]), 0);

    // One frame
    row_valid = 1'b1;
    wait_start();
    row_valid = 1'b0;
    wait_rd(1);
    wait_idle();
    cmp("frame_se", 0, last_se[0], 9);
    cmp("frame_rises", 0, last_rise[0], 36);
    cmp("frame_cs_low", 0, last_low[0], 155);
    cmp("frame_se", 1, last_se[1], 9);
    cmp("frame_rises", 1, last_rise[1], 36);
    cmp("frame_cs_low", 1, last_low[1], 83);
    cmp("nib0", 0, int'(nib_log[0]), 32'hA);
    cmp("nib1", 0, int'(nib_log[1]), 32'h1);
    cmp("nib2", 0, int'(nib_log[2]), 32'hB);
    cmp("nib3", 0, int'(nib_log[3]), 32'h2);
    cmp("nib4", 0, int'(nib_log[4]), 32'hC);
    cmp("nib7", 0, int'(nib_log[7]), 32'h4);
    cmp("nib32", 0, int'(nib_log[32]), 32'h0);
    cmp("nib33", 0, int'(nib_log[33]), 32'h7);
    cmp("nib34", 0, int'(nib_log[34]), 32'h0);
    cmp("nib35", 0, int'(nib_log[35]), 32'h7);

    // Back-to-back rows
    rd0 = rd_cnt[0];
    row_valid = 1'b1;
    wait_rd(rd0 + 2);
    cmp("b2b_gap", 0, last_gap[0], 5);
    cmp("b2b_gap", 1, last_gap[1], 5);
    cmp("b2b_cs_low", 0, last_low[0], 155);
    row_valid = 1'b0;
    wait_idle();

    // tx_enable dropped during word 4
    rd0 = rd_cnt[0];
    row_valid = 1'b1;
    wait_start();
    wait_se(4);
    tx_enable = 1'b0;
    wait_rd(rd0 + 1);
    step(40);
    cmp("txoff_se", 0, last_se[0], 9);
    cmp("txoff_rd_cnt", 0, rd_cnt[0], rd0 + 1);
    cmp("txoff_cs_n", 0, int'(csn[0]), 1);
    cmp("txoff_busy", 1, int'(busy[1]), 0);

    // Reset during nibble 2 of word 5
    tx_enable = 1'b1;
    wait_start();
    wait_se(5);
    step(6);
    #2;
    rd0 = rd_cnt[0];
    rst_n = 1'b0;
    #1;
    cmp("abort_cs_n", 0, int'(csn[0]), 1);
    cmp("abort_sclk", 0, int'(sclk[0]), 0);
    cmp("abort_oe", 0, int'(oe[0]), 0);
    cmp("abort_io", 0, int'(io[0]), 0);
    cmp("abort_row_done", 0, int'(rd[0]), 0);
    step(3);
    rst_n = 1'b1;
    cmp("abort_no_rd", 0, rd_cnt[0], rd0);
    wait_start();
    row_valid = 1'b0;
    wait_rd(rd0 + 1);
    wait_idle();
    cmp("post_rst_se", 0, last_se[0], 9);
    cmp("post_rst_cs_low", 0, last_low[0], 155);
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qspi_row_tx.md
Name: qspi_row_tx

Overview:
- Downstream neighbour of the FIFO-to-SPI row interface.
- Pulls 16-bit words from that interface and serialises each one onto a 4-lane QSPI bus, MSB nibble first.
- Asserts shift_en to advance the interface to its next word, and frames every row (8 data words plus 1 address word) inside a single chip-select window.
- SPI mode 0, driven entirely from the system clock.

Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period; minimum 1.
- WORDS_PER_ROW, 9: words sent per row frame (8 data words, then 1 address word).
- CS_SETUP, 2: clk cycles from cs_n falling to the first SCLK activity.
- CS_GAP, 4: minimum clk cycles cs_n stays high between frames.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tx_enable  in  1  permit new frames to start
- row_valid  in  1  FIFO holds a complete row (not empty)
- rdata_spi  in  16  current word from the row interface
- shift_en  out  1  one-cycle pulse; word captured, upstream advances
- qspi_sclk  out  1  serial clock, idle low
- qspi_cs_n  out  1  chip select, active low
- qspi_io  out  4  data lanes
- qspi_oe  out  1  lane output enable
- busy  out  1  frame in progress (cs_n low or gap running)
- row_done  out  1  one-cycle pulse when the last nibble of a frame completes

Behaviour:
- Reset values: shift_en=0, qspi_sclk=0, qspi_cs_n=1, qspi_io=0, qspi_oe=0, busy=0, row_done=0. All internal counters and the shift register clear to 0; FSM goes to IDLE.
- Reset asserted mid-frame aborts immediately. No row_done is issued and the bus returns to idle values that same instant.
- All outputs are registered.

FSM states: IDLE, SETUP, LOAD, SHIFT, GAP.
- IDLE: if tx_enable && row_valid, go to SETUP next cycle with cs_n=0, oe=1, word_cnt=0. Otherwise stay. row_valid is only sampled here.
- SETUP: hold for CS_SETUP cycles with sclk=0, then go to LOAD.
- LOAD (exactly 1 cycle):
  - shift_en=1.
  - sreg <= rdata_spi in this same cycle; upstream changes rdata_spi the cycle after.
  - qspi_io <= rdata_spi[15:12], nib_cnt=0, then go to SHIFT.
- SHIFT, per nibble:
  - sclk low for CLK_DIV cycles, then high for CLK_DIV cycles. The receiver samples on the rising edge.
  - On each falling edge (high-to-low) the next nibble is placed on qspi_io: sreg shifts left by 4 and io takes the new sreg[15:12].
  - After the 4th high phase ends, sclk returns low and one of two things happens:
    - If word_cnt < WORDS_PER_ROW-1: word_cnt+1, go to LOAD. The LOAD cycle extends that low phase by 1 cycle.
    - Otherwise: row_done=1, cs_n=1, oe=0, io=0, go to GAP.
- GAP: hold cs_n high for CS_GAP cycles (busy stays 1), then go to IDLE.
- Cycle budget at defaults: 17 clk per word, 2 + 9*17 = 155 cycles with cs_n low, 159 cycles from frame start to IDLE.
- shift_en count per frame is exactly WORDS_PER_ROW, so there are 9 pulses at defaults.
- tx_enable deasserted mid-frame: the current frame completes normally and no new frame starts.
- row_valid dropping mid-frame: ignored. Upstream guarantees the row stays resident until the final shift_en.
- Frames never overlap. Back-to-back rows are separated by at least CS_GAP+1 cycles of cs_n high.
- Counter widths: word_cnt is $clog2(WORDS_PER_ROW+1) bits, nib_cnt 2 bits, div_cnt $clog2(CLK_DIV+1) bits. There is no wrap inside a frame.

Test Plan:
- Reset, then idle with tx_enable=1, row_valid=0 for 50 cycles -> cs_n=1, sclk=0, shift_en never pulses, busy=0.
- One frame: rdata_spi supplies 0xA1B2, 0xC3D4, ... (9 words, last one 0x0707) -> io nibbles sampled on sclk rising edges are A,1,B,2,C,3,D,4,...,0,7,0,7. Expect 9 shift_en pulses, 36 sclk rising edges, cs_n low for 155 cycles, and row_done on the cycle cs_n rises.
- Word-capture timing: rdata_spi changes on the cycle after each shift_en -> the transmitted word equals the pre-change value every time, with no nibble mixing between words.
- Back-to-back rows with row_valid held high -> the second frame's cs_n falls exactly CS_GAP+1 cycles after the first row_done. Repeat with CLK_DIV=1: 9 cycles per word, 83 cycles with cs_n low.
- tx_enable dropped at word 4 -> the frame finishes with all 9 words and the bench stays in IDLE afterwards despite row_valid=1.
- rst_n asserted at nibble 2 of word 5 -> on the same edge cs_n=1, sclk=0, oe=0, no row_done. After release, the next frame starts cleanly with word_cnt=0.
